// File: rtl/add_h_border_if.sv
// Tagged multi-flux FIFO port bundles for add_h_border.
//
// add_h_border_rd_if : read side of Lanes first-word-fall-through FIFOs.
//   dout  [Lanes*Width] head word per lane (lane i at bits [i*Width +: Width])
//   empty [Lanes]       per-lane empty flag
//   read  [Lanes]       per-lane pop strobe, driven by the consumer
// add_h_border_wr_if : write side of one output FIFO.
//   din   [Width]       word to push
//   write               push strobe
//   full                FIFO full flag
// The master modport is the side that issues read/write strobes.

interface add_h_border_rd_if #(
  parameter int unsigned Lanes = 2,
  parameter int unsigned Width = 8
);
  logic [Lanes*Width-1:0] dout;
  logic [Lanes-1:0]       empty;
  logic [Lanes-1:0]       read;

  modport master (input dout, input empty, output read);
  modport slave (output dout, output empty, input read);
endinterface

interface add_h_border_wr_if #(
  parameter int unsigned Width = 19
);
  logic [Width-1:0] din;
  logic             write;
  logic             full;

  modport master (output din, output write, input full);
  modport slave (input din, input write, output full);
endinterface

// File: rtl/add_h_border.sv
// add_h_border: multi-flux horizontal border generator.
//
// For each flux it pops a block size N, then streams an NxN block of inner
// samples row by row, emitting BORDER left-pad samples, the N inner samples and
// BORDER right-pad samples per row. Output words are {flux tag, sample}.
// Pads replicate the row's first/last sample, or are zero when the build macro
// ADD_H_BORDER_ZERO_PAD_EN is defined.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   read_port_size FLUX-lane size FIFOs (low SIZE_WIDTH bits of each word = N)
//   read_port_A    FLUX-lane sample FIFOs, first-word-fall-through
//   write_port     tagged output FIFO
//
// One action per cycle: the lowest-index eligible flux is served. All strobes
// and din are combinational from registered state and the FIFO flags.

module add_h_border #(
  parameter int unsigned FLUX       = 2,
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned SIZE_WIDTH = 7,
  parameter int unsigned BORDER     = 4,
  parameter int unsigned TAG_WIDTH  = $clog2(FLUX)
) (
  input  logic             clk,
  input  logic             rst,
  add_h_border_rd_if.master read_port_size,
  add_h_border_rd_if.master read_port_A,
  add_h_border_wr_if.master write_port
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_MID   = 2'd2;
  localparam logic [1:0] ST_RIGHT = 2'd3;

  localparam int SW = int'(TAG_WIDTH + SIZE_WIDTH);
  localparam int AW = int'(TAG_WIDTH + DATA_WIDTH);

  localparam logic [SIZE_WIDTH-1:0] BorderM1 = SIZE_WIDTH'(BORDER - 1);

  // Per-flux state
  logic [1:0]            state_q [FLUX];
  logic [1:0]            state_d [FLUX];
  logic [SIZE_WIDTH-1:0] cnt_h_q [FLUX];
  logic [SIZE_WIDTH-1:0] cnt_h_d [FLUX];
  logic [SIZE_WIDTH-1:0] cnt_v_q [FLUX];
  logic [SIZE_WIDTH-1:0] cnt_v_d [FLUX];
  logic [SIZE_WIDTH-1:0] size_q  [FLUX];
  logic [SIZE_WIDTH-1:0] size_d  [FLUX];
`ifndef ADD_H_BORDER_ZERO_PAD_EN
  logic [DATA_WIDTH-1:0] hold_q  [FLUX];
  logic [DATA_WIDTH-1:0] hold_d  [FLUX];
`endif

  logic [FLUX-1:0]       eligible;
  logic                  found;
  logic [TAG_WIDTH-1:0]  sel;
  logic [SIZE_WIDTH-1:0] size_n;
  logic [DATA_WIDTH-1:0] a_head;
  logic [DATA_WIDTH-1:0] left_val;
  logic [DATA_WIDTH-1:0] right_val;
  logic [FLUX-1:0]       size_rd;
  logic [FLUX-1:0]       a_rd;
  logic                  wr;
  logic [AW-1:0]         din;

  // Tag fields of the input words carry no information for this stage.
  logic unused_tags;
  assign unused_tags = ^{read_port_size.dout, read_port_A.dout};

  always_comb begin
    // Eligibility per flux
    eligible = '0;
    for (int f = 0; f < int'(FLUX); f++) begin
      case (state_q[f])
        ST_IDLE: eligible[f] = !read_port_size.empty[f];
`ifdef ADD_H_BORDER_ZERO_PAD_EN
        ST_LEFT: eligible[f] = !write_port.full;
`else
        ST_LEFT: eligible[f] = !read_port_A.empty[f] && !write_port.full;
`endif
        ST_MID:  eligible[f] = !read_port_A.empty[f] && !write_port.full;
        default: eligible[f] = !write_port.full;
      endcase
    end

    // Fixed priority: scanning downwards leaves the lowest eligible index in sel.
    found = 1'b0;
    sel   = '0;
    for (int f = int'(FLUX) - 1; f >= 0; f--) begin
      if (eligible[f]) begin
        found = 1'b1;
        sel   = TAG_WIDTH'(f);
      end
    end

    size_n = read_port_size.dout[int'(sel) * SW +: SIZE_WIDTH];
    a_head = read_port_A.dout[int'(sel) * AW +: DATA_WIDTH];

`ifdef ADD_H_BORDER_ZERO_PAD_EN
    left_val  = '0;
    right_val = '0;
`else
    left_val  = a_head;
    right_val = hold_q[sel];
    hold_d    = hold_q;
`endif

    state_d = state_q;
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    size_d  = size_q;
    size_rd = '0;
    a_rd    = '0;
    wr      = 1'b0;
    din     = '0;

    if (found && !rst) begin
      unique case (state_q[sel])
        ST_IDLE: begin
          size_rd[sel] = 1'b1;
          size_d[sel]  = size_n;
          cnt_h_d[sel] = '0;
          cnt_v_d[sel] = '0;
          // N == 0 is an empty block: consume the size and stay idle.
          state_d[sel] = (size_n == '0) ? ST_IDLE : ST_LEFT;
        end
        ST_LEFT: begin
          // Replicate the row's first sample without consuming it.
          wr  = 1'b1;
          din = {sel, left_val};
          if (cnt_h_q[sel] == BorderM1) begin
            cnt_h_d[sel] = '0;
            state_d[sel] = ST_MID;
          end else begin
            cnt_h_d[sel] = cnt_h_q[sel] + SIZE_WIDTH'(1);
          end
        end
        ST_MID: begin
          a_rd[sel] = 1'b1;
          wr        = 1'b1;
          din       = {sel, a_head};
`ifndef ADD_H_BORDER_ZERO_PAD_EN
          hold_d[sel] = a_head;
`endif
          if (cnt_h_q[sel] == size_q[sel] - SIZE_WIDTH'(1)) begin
            cnt_h_d[sel] = '0;
            state_d[sel] = ST_RIGHT;
          end else begin
            cnt_h_d[sel] = cnt_h_q[sel] + SIZE_WIDTH'(1);
          end
        end
        ST_RIGHT: begin
          // Right pad comes from hold, so an empty A FIFO cannot stall it.
          wr  = 1'b1;
          din = {sel, right_val};
          if (cnt_h_q[sel] == BorderM1) begin
            cnt_h_d[sel] = '0;
            if (cnt_v_q[sel] == size_q[sel] - SIZE_WIDTH'(1)) begin
              cnt_v_d[sel] = '0;
              state_d[sel] = ST_IDLE;
            end else begin
              cnt_v_d[sel] = cnt_v_q[sel] + SIZE_WIDTH'(1);
              state_d[sel] = ST_LEFT;
            end
          end else begin
            cnt_h_d[sel] = cnt_h_q[sel] + SIZE_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign read_port_size.read = size_rd;
  assign read_port_A.read    = a_rd;
  assign write_port.write    = wr;
  assign write_port.din      = din;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int f = 0; f < int'(FLUX); f++) begin
        state_q[f] <= ST_IDLE;
        cnt_h_q[f] <= '0;
        cnt_v_q[f] <= '0;
        size_q[f]  <= '0;
`ifndef ADD_H_BORDER_ZERO_PAD_EN
        hold_q[f]  <= '0;
`endif
      end
    end else begin
      state_q <= state_d;
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      size_q  <= size_d;
`ifndef ADD_H_BORDER_ZERO_PAD_EN
      hold_q  <= hold_d;
`endif
    end
  end

endmodule

// File: tb/tb_add_h_border.sv
// Self-checking bench for add_h_border (FLUX=2, DATA_WIDTH=18, SIZE_WIDTH=7,
// BORDER=4). Input FIFOs and the output FIFO are modelled with queues; a
// monitor drives the flags on the falling edge and samples strobes just before
// the rising edge.

module tb_add_h_border;

  localparam int FLUX   = 2;
  localparam int DW     = 18;
  localparam int SZW    = 7;
  localparam int BORDER = 4;
  localparam int TW     = 1;

  logic clk;
  logic rst;

  add_h_border_rd_if #(.Lanes(FLUX), .Width(TW + SZW)) sz_if ();
  add_h_border_rd_if #(.Lanes(FLUX), .Width(TW + DW))  a_if ();
  add_h_border_wr_if #(.Width(TW + DW))                wr_if ();

  add_h_border #(
    .FLUX       (FLUX),
    .DATA_WIDTH (DW),
    .SIZE_WIDTH (SZW),
    .BORDER     (BORDER)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .read_port_size (sz_if),
    .read_port_A    (a_if),
    .write_port     (wr_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO models and monitor state
  logic [7:0]  s0[$];
  logic [7:0]  s1[$];
  logic [18:0] a0[$];
  logic [18:0] a1[$];
  logic [18:0] out_q[$];
  logic [18:0] exp_q[$];
  int          sz_pop_cyc[$];
  logic        bp;
  logic        full_r;
  int          viol;
  int          rst_viol;
  int          cyc;
  int          errors;
  int          checks;

  typedef struct {
    int flux;
    int n;
    int base;
    bit bp;
    int exp_cnt;
    int idx_a;
    int exp_a;
    int idx_b;
    int exp_b;
  } vec_t;

  vec_t vecs[5];

  function automatic int pad_exp(input int v);
`ifdef ADD_H_BORDER_ZERO_PAD_EN
    return v & 0;
`else
    return v;
`endif
  endfunction

  function automatic logic [18:0] word(input int flux, input int v);
    return {1'(flux), 18'(v)};
  endfunction

  // Reference expansion: each row is pad(first), inner samples, pad(last).
  function automatic void add_exp(input int flux, input int n, input int base, input int step);
    for (int r = 0; r < n; r++) begin
      int first;
      int last;
      first = base + r * n * step;
      last  = first + (n - 1) * step;
      for (int b = 0; b < BORDER; b++) exp_q.push_back(word(flux, pad_exp(first)));
      for (int c = 0; c < n; c++) exp_q.push_back(word(flux, first + c * step));
      for (int b = 0; b < BORDER; b++) exp_q.push_back(word(flux, pad_exp(last)));
    end
  endfunction

  task automatic push_size(input int flux, input int n);
    if (flux == 0) s0.push_back({1'(flux), 7'(n)});
    else s1.push_back({1'(flux), 7'(n)});
  endtask

  task automatic push_samples(input int flux, input int base, input int step,
                              input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      if (flux == 0) a0.push_back(word(flux, base + k * step));
      else a1.push_back(word(flux, base + k * step));
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_seq(input string name, input int flux);
    logic [18:0] got[$];
    int bad;
    bad = -1;
    foreach (out_q[i]) if (int'(out_q[i][18]) == flux) got.push_back(out_q[i]);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && got[i] !== exp_q[i]) bad = i;
    end
    checks++;
    if (got.size() != exp_q.size() || bad >= 0) begin
      errors++;
      if (bad >= 0)
        $display("FAIL %s: word %0d got %h, required %h", name, bad, got[bad], exp_q[bad]);
      else
        $display("FAIL %s: got %0d words, required %0d", name, got.size(), exp_q.size());
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_until(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (out_q.size() < n && c < budget) begin
      step_cycles(1);
      c++;
    end
    check_int({name, " writes before timeout"}, (out_q.size() >= n) ? n : out_q.size(), n);
    step_cycles(6);
  endtask

  // Monitor: drive FIFO flags on negedge, sample strobes 2 time units later.
  always begin
    @(negedge clk);
    sz_if.empty = {s1.size() == 0, s0.size() == 0};
    sz_if.dout  = {(s1.size() != 0) ? s1[0] : 8'h00, (s0.size() != 0) ? s0[0] : 8'h00};
    a_if.empty  = {a1.size() == 0, a0.size() == 0};
    a_if.dout   = {(a1.size() != 0) ? a1[0] : 19'h0, (a0.size() != 0) ? a0[0] : 19'h0};
    if (bp) full_r = ~full_r;
    else full_r = 1'b0;
    wr_if.full = full_r;
    #2;
    if (rst) begin
      if (sz_if.read != 2'b00 || a_if.read != 2'b00 || wr_if.write) rst_viol++;
    end else begin
      if ($countones({sz_if.read, a_if.read}) > 1) viol++;
      if (a_if.read != 2'b00 && !wr_if.write) viol++;
      if ((a_if.read != 2'b00 || wr_if.write) && wr_if.full) viol++;
      if (sz_if.read[0]) begin
        if (s0.size() == 0) viol++;
        else begin
          void'(s0.pop_front());
          sz_pop_cyc.push_back(cyc);
        end
      end
      if (sz_if.read[1]) begin
        if (s1.size() == 0) viol++;
        else void'(s1.pop_front());
      end
      if (a_if.read[0]) begin
        if (a0.size() == 0) viol++;
        else void'(a0.pop_front());
      end
      if (a_if.read[1]) begin
        if (a1.size() == 0) viol++;
        else void'(a1.pop_front());
      end
      if (wr_if.write) out_q.push_back(wr_if.din);
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    int r0;
    int cnt;
    int first1;
    int last0;

    errors   = 0;
    checks   = 0;
    viol     = 0;
    rst_viol = 0;
    cyc      = 0;
    bp       = 1'b0;
    full_r   = 1'b0;
    rst      = 1'b1;
    sz_if.empty = '1;
    sz_if.dout  = '0;
    a_if.empty  = '1;
    a_if.dout   = '0;
    wr_if.full  = 1'b0;

    //            flux n  base bp   cnt idx_a exp_a idx_b exp_b
    vecs[0] = '{0, 4, 1, 1'b0, 48, 5,  2,  36, pad_exp(13)};
    vecs[1] = '{0, 4, 1, 1'b1, 48, 11, pad_exp(4), 43, 16};
    vecs[2] = '{1, 1, 7, 1'b0, 9,  4,  7,  8,  pad_exp(7)};
    vecs[3] = '{1, 2, 5, 1'b0, 20, 0,  pad_exp(5), 5, 6};
    vecs[4] = '{0, 0, 0, 1'b0, 0,  -1, 0,  -1, 0};

    // Reset: FIFOs hold data but nothing may move while rst is high.
    push_size(0, 1);
    push_samples(0, 42, 1, 0, 1);
    step_cycles(4);
    check_int("reset strobes", rst_viol, 0);
    check_int("reset no size pop", s0.size(), 1);
    check_int("reset no writes", out_q.size(), 0);
    rst = 1'b0;
    run_until("post-reset N=1", 9, 100);
    exp_q.delete();
    add_exp(0, 1, 42, 1);
    check_seq("post-reset N=1 seq", 0);

    // Table-driven single-flux blocks
    foreach (vecs[i]) begin
      out_q.delete();
      v0 = viol;
      bp = vecs[i].bp;
      push_size(vecs[i].flux, vecs[i].n);
      push_samples(vecs[i].flux, vecs[i].base, 1, 0, vecs[i].n * vecs[i].n);
      run_until($sformatf("vec%0d", i), vecs[i].exp_cnt, 400);
      bp = 1'b0;
      check_int($sformatf("vec%0d count", i), out_q.size(), vecs[i].exp_cnt);
      if (vecs[i].idx_a >= 0)
        check_int($sformatf("vec%0d word%0d", i, vecs[i].idx_a),
                  (vecs[i].idx_a < out_q.size()) ? int'(out_q[vecs[i].idx_a][17:0]) : -1,
                  vecs[i].exp_a);
      if (vecs[i].idx_b >= 0)
        check_int($sformatf("vec%0d word%0d", i, vecs[i].idx_b),
                  (vecs[i].idx_b < out_q.size()) ? int'(out_q[vecs[i].idx_b][17:0]) : -1,
                  vecs[i].exp_b);
      exp_q.delete();
      add_exp(vecs[i].flux, vecs[i].n, vecs[i].base, 1);
      check_seq($sformatf("vec%0d seq", i), vecs[i].flux);
      check_int($sformatf("vec%0d drained", i), s0.size() + s1.size() + a0.size() + a1.size(), 0);
      check_int($sformatf("vec%0d handshake", i), viol - v0, 0);
    end

    // Both fluxes ready: flux 0 block completes before flux 1 starts.
    out_q.delete();
    push_size(0, 2);
    push_samples(0, 10, 10, 0, 4);
    push_size(1, 2);
    push_samples(1, 50, 10, 0, 4);
    run_until("arb", 40, 200);
    cnt = 0;
    for (int i = 0; i < 20 && i < out_q.size(); i++) if (out_q[i][18] == 1'b0) cnt++;
    check_int("arb flux0 first", cnt, 20);
    exp_q.delete();
    add_exp(0, 2, 10, 10);
    check_seq("arb flux0 seq", 0);
    exp_q.delete();
    add_exp(1, 2, 50, 10);
    check_seq("arb flux1 seq", 1);

    // Flux 0 starves mid-row: flux 1 proceeds during the stall.
    out_q.delete();
    push_size(0, 2);
    push_samples(0, 10, 10, 0, 1);
    push_size(1, 2);
    push_samples(1, 50, 10, 0, 4);
    step_cycles(12);
    push_samples(0, 10, 10, 1, 4);
    run_until("stall", 40, 200);
    first1 = -1;
    last0  = -1;
    foreach (out_q[i]) begin
      if (out_q[i][18] == 1'b1 && first1 < 0) first1 = i;
      if (out_q[i][18] == 1'b0) last0 = i;
    end
    check_int("stall interleave", (first1 >= 0 && first1 < last0) ? 1 : 0, 1);
    exp_q.delete();
    add_exp(0, 2, 10, 10);
    check_seq("stall flux0 seq", 0);
    exp_q.delete();
    add_exp(1, 2, 50, 10);
    check_seq("stall flux1 seq", 1);

    // N=0 then N=1: the second size is popped on the very next cycle.
    out_q.delete();
    sz_pop_cyc.delete();
    push_size(0, 0);
    push_size(0, 1);
    push_samples(0, 9, 1, 0, 1);
    run_until("n0", 9, 100);
    check_int("n0 size pops", sz_pop_cyc.size(), 2);
    check_int("n0 back-to-back", (sz_pop_cyc.size() == 2) ? sz_pop_cyc[1] - sz_pop_cyc[0] : -1, 1);
    exp_q.delete();
    add_exp(0, 1, 9, 1);
    check_seq("n0 then n1 seq", 0);

    // Reset after 20 writes of an N=4 block abandons it.
    out_q.delete();
    push_size(0, 4);
    push_samples(0, 1, 1, 0, 16);
    cnt = 0;
    while (out_q.size() < 20 && cnt < 100) begin
      step_cycles(1);
      cnt++;
    end
    check_int("midrst reached 20", out_q.size(), 20);
    r0  = rst_viol;
    rst = 1'b1;
    step_cycles(3);
    check_int("midrst strobes", rst_viol - r0, 0);
    check_int("midrst no writes", out_q.size(), 20);
    s0.delete();
    a0.delete();
    out_q.delete();
    rst = 1'b0;
    push_size(0, 1);
    push_samples(0, 3, 1, 0, 1);
    run_until("midrst fresh", 9, 100);
    exp_q.delete();
    add_exp(0, 1, 3, 1);
    check_seq("midrst fresh seq", 0);
    check_int("overall handshake", viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
